// File: rtl/hex_display_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_scanner_if
// Brief    : CPU-side register bus for the multiplexed hex display scanner.
// Revision : 1.0  initial release
// ============================================================================
interface hex_display_scanner_if;
    logic        iChip_select_n;
    logic        iWrite_n;
    logic        iAddress;
    logic [31:0] iData;
    logic [31:0] oReadData;

    modport master (
        output iChip_select_n, iWrite_n, iAddress, iData,
        input  oReadData
    );

    modport slave (
        input  iChip_select_n, iWrite_n, iAddress, iData,
        output oReadData
    );
endinterface
`default_nettype wire

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_scanner
// Brief    : Time-multiplexed active-low 7-segment driver with VALUE/CTRL
//            registers; optional HEX_LEADING_ZERO_BLANK_EN hides leading zeros.
// Revision : 1.0  initial release
// ============================================================================
module hex_display_scanner #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  wire                     iClk,
    input  wire                     iReset_n,
    hex_display_scanner_if.slave    bus,
    output logic [6:0]              oSeg_n,
    output logic [NUM_DIGITS-1:0]   oDigit_n
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] c_presMax = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] c_dead    = PW'(DEAD_CYCLES);
    localparam logic [IW-1:0] c_idxMax  = IW'(NUM_DIGITS - 1);

    logic [31:0]           r_value;
    logic                  r_enable;
    logic [NUM_DIGITS-1:0] r_blank;
    logic [PW-1:0]         r_prescaler;
    logic [IW-1:0]         r_index;

    logic [31:0]           w_ctrlRead;
    logic [NUM_DIGITS-1:0] w_suppress;
    logic [NUM_DIGITS-1:0] w_digitSel;
    logic [3:0]            w_nibble;
    logic                  w_lit;

    function automatic logic [6:0] segDecode(input logic [3:0] nib);
        case (nib)
            4'h0: segDecode = 7'h40;
            4'h1: segDecode = 7'h79;
            4'h2: segDecode = 7'h24;
            4'h3: segDecode = 7'h30;
            4'h4: segDecode = 7'h19;
            4'h5: segDecode = 7'h12;
            4'h6: segDecode = 7'h02;
            4'h7: segDecode = 7'h78;
            4'h8: segDecode = 7'h00;
            4'h9: segDecode = 7'h10;
            4'hA: segDecode = 7'h08;
            4'hB: segDecode = 7'h03;
            4'hC: segDecode = 7'h46;
            4'hD: segDecode = 7'h21;
            4'hE: segDecode = 7'h06;
            default: segDecode = 7'h0E;
        endcase
    endfunction

`ifdef HEX_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more-significant digit are 0.
    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_suppress
            if (k == 0) begin : g_first
                assign w_suppress[k] = 1'b0;
            end else begin : g_upper
                assign w_suppress[k] = ~|r_value[4*NUM_DIGITS-1:4*k];
            end
        end
    endgenerate
`else
    assign w_suppress = '0;
`endif

    always_comb begin
        w_ctrlRead = '0;
        w_ctrlRead[0] = r_enable;
        w_ctrlRead[8 +: NUM_DIGITS] = r_blank;
    end

    assign w_nibble = r_value[{r_index, 2'b00} +: 4];
    assign w_lit    = r_enable && (r_prescaler >= c_dead)
                      && !r_blank[r_index] && !w_suppress[r_index];

    always_comb begin
        w_digitSel = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == r_index) w_digitSel[k] = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_value       <= '0;
            r_enable      <= 1'b0;
            r_blank       <= '0;
            r_prescaler   <= '0;
            r_index       <= '0;
            bus.oReadData <= '0;
            oSeg_n        <= 7'h7F;
            oDigit_n      <= '1;
        end else begin
            if (!bus.iChip_select_n && !bus.iWrite_n) begin
                if (bus.iAddress) begin
                    r_enable <= bus.iData[0];
                    r_blank  <= bus.iData[8 +: NUM_DIGITS];
                end else begin
                    r_value  <= bus.iData;
                end
            end
            if (!bus.iChip_select_n && bus.iWrite_n) begin
                bus.oReadData <= bus.iAddress ? w_ctrlRead : r_value;
            end

            if (!r_enable) begin
                r_prescaler <= '0;
                r_index     <= '0;
            end else if (r_prescaler == c_presMax) begin
                r_prescaler <= '0;
                r_index     <= (r_index == c_idxMax) ? '0 : r_index + 1'b1;
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end

            // Output stage lags the counters by one cycle.
            if (w_lit) begin
                oDigit_n <= w_digitSel;
                oSeg_n   <= segDecode(w_nibble);
            end else begin
                oDigit_n <= '1;
                oSeg_n   <= 7'h7F;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_scanner
// Brief    : Directed self-checking bench (4 digits, 4-cycle slots, 1 dead).
// Revision : 1.0  initial release
// ============================================================================
module tb_hex_display_scanner;
    localparam int N = 4;
    localparam int S = 4;
    localparam int D = 1;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic         iClk = 1'b0;
    logic         iReset_n = 1'b0;
    logic [6:0]   oSeg_n;
    logic [N-1:0] oDigit_n;
    int           errors = 0;
    int           checks = 0;

    hex_display_scanner_if bus ();

    hex_display_scanner #(.NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYCLES(D)) dut (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .bus      (bus),
        .oSeg_n   (oSeg_n),
        .oDigit_n (oDigit_n)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write lands on the next posedge.
    task automatic busWrite(input logic addr, input logic [31:0] data);
        bus.iChip_select_n = 1'b0;
        bus.iWrite_n = 1'b0;
        bus.iAddress = addr;
        bus.iData = data;
        @(negedge iClk);
        bus.iChip_select_n = 1'b1;
        bus.iWrite_n = 1'b1;
    endtask

    task automatic busRead(input logic addr, input logic [31:0] exp, input string tag);
        bus.iChip_select_n = 1'b0;
        bus.iWrite_n = 1'b1;
        bus.iAddress = addr;
        @(negedge iClk);
        bus.iChip_select_n = 1'b1;
        check(tag, bus.oReadData, exp);
    endtask

    task automatic expectOut(input string tag, input logic [N-1:0] dig, input logic [6:0] seg);
        check({tag, "_dig"}, 32'(oDigit_n), 32'(dig));
        check({tag, "_seg"}, 32'(oSeg_n), 32'(seg));
    endtask

    // Restart the scan from index 0 and compare two full frames.
    task automatic runScan(input logic [31:0] value, input logic [31:0] ctrl, input string tag);
        logic [N-1:0] mask;
        logic         supp;
        logic [15:0]  v16;
        int           phase;
        int           dig;
        mask = ctrl[8 +: N];
        v16  = value[15:0];
        busWrite(1'b1, 32'h0);
        busWrite(1'b0, value);
        busWrite(1'b1, ctrl);
        for (int i = 1; i <= 2 * N * S; i++) begin
            @(negedge iClk);
            phase = (i - 1) % S;
            dig   = ((i - 1) / S) % N;
            supp  = 1'b0;
`ifdef HEX_LEADING_ZERO_BLANK_EN
            if (dig > 0 && (v16 >> (4 * dig)) == 16'h0) supp = 1'b1;
`endif
            if (phase >= D && !mask[dig] && !supp)
                expectOut($sformatf("%s_e%0d", tag, i), ~(N'(1) << dig), SEG_TAB[v16[4*dig +: 4]]);
            else
                expectOut($sformatf("%s_e%0d", tag, i), '1, 7'h7F);
        end
    endtask

    initial begin
        bus.iChip_select_n = 1'b1;
        bus.iWrite_n = 1'b1;
        bus.iAddress = 1'b0;
        bus.iData = '0;
        repeat (2) @(negedge iClk);
        expectOut("reset", 4'hF, 7'h7F);
        check("reset_rd", bus.oReadData, 32'h0);
        iReset_n = 1'b1;
        @(negedge iClk);
        expectOut("idle", 4'hF, 7'h7F);

        runScan(32'h0000_3A1F, 32'h1, "scan");

        busRead(1'b0, 32'h0000_3A1F, "rd_value");
        busWrite(1'b1, 32'hFFFF_0201);
        busRead(1'b1, 32'h0000_0201, "rd_ctrl");

        runScan(32'h0000_3A1F, 32'h0000_0201, "blank");

        // Disable mid-slot, then re-enable and write VALUE mid-slot.
        busWrite(1'b1, 32'h0);
        busWrite(1'b1, 32'h1);                 // enable at E0
        @(negedge iClk); expectOut("en_e1", 4'hF, 7'h7F);
        @(negedge iClk); expectOut("en_e2", 4'hE, 7'h0E);
        busWrite(1'b1, 32'h0);                 // E3 still lit from old enable
        expectOut("dis_e3", 4'hE, 7'h0E);
        @(negedge iClk); expectOut("dis_e4", 4'hF, 7'h7F);
        busWrite(1'b1, 32'h1);                 // re-enable at E5
        expectOut("dis_e5", 4'hF, 7'h7F);
        @(negedge iClk); expectOut("re_e6", 4'hF, 7'h7F);
        @(negedge iClk); expectOut("re_e7", 4'hE, 7'h0E);
        busWrite(1'b0, 32'h0000_0008);         // E8 uses old value
        expectOut("mw_e8", 4'hE, 7'h0E);
        @(negedge iClk); expectOut("mw_e9", 4'hE, 7'h00);
        @(negedge iClk); expectOut("mw_e10", 4'hF, 7'h7F);
        @(negedge iClk); expectOut("mw_e11", 4'hD, 7'h40);

        // Asynchronous reset between edges.
        @(posedge iClk);
        #2 iReset_n = 1'b0;
        #1 expectOut("async_rst", 4'hF, 7'h7F);
        @(negedge iClk);
        iReset_n = 1'b1;
        busRead(1'b0, 32'h0, "rst_rd_value");
        busRead(1'b1, 32'h0, "rst_rd_ctrl");
        expectOut("rst_idle", 4'hF, 7'h7F);

        runScan(32'h0000_0050, 32'h1, "lz50");
        runScan(32'h0000_0000, 32'h1, "lz0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
Bus-mapped, time-multiplexed driver for a row of common-anode 7-segment digits. It is downstream of the single-digit hex register. The CPU writes one 32-bit value (one nibble per digit) plus a control word. The block decodes each nibble to active-low segments and cycles the digit enables with a programmable scan rate and inter-digit dead time.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..8); digit k shows iData nibble k of VALUE.
SCAN_DIV, 50000, iClk cycles per digit slot (>=2).
DEAD_CYCLES, 2, cycles at start of each slot with all digits off (0..SCAN_DIV-1).

Ports:
iClk  input  1  clock
iReset_n  input  1  asynchronous active-low reset
iChip_select_n  input  1  bus select, active-low
iWrite_n  input  1  write strobe, active-low; read when high with select low
iAddress  input  1  0 = VALUE, 1 = CTRL
iData  input  32  write data
oReadData  output  32  registered read data
oSeg_n  output  7  segments g..a, active-low
oDigit_n  output  NUM_DIGITS  digit enables, active-low, at most one low

Behaviour:
- Reset is asserted via iReset_n, asynchronous, active-low; clock is iClk. While in reset, all state clears immediately.
- Reset values: VALUE=0, CTRL=0, prescaler=0, index=0, oReadData=0, oSeg_n=7'h7F, oDigit_n=all ones.
- Write: at posedge with ~iChip_select_n & ~iWrite_n, the addressed register takes iData. It is visible to the output stage on the next edge.
- CTRL fields: bit0 ENABLE; bits[8+NUM_DIGITS-1:8] BLANK mask, where bit 8+k=1 forces digit k off. Other bits are ignored and read as 0.
- Read: at posedge with ~iChip_select_n & iWrite_n, oReadData <= addressed register. This gives 1-cycle latency. oReadData holds its value otherwise.
- ENABLE=0: prescaler and index are held at 0. Next edge: oDigit_n=all ones, oSeg_n=7'h7F.
- ENABLE=1, prescaler:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0, and index advances. index wraps NUM_DIGITS-1 -> 0.
- Output stage is registered and computed from the current prescaler and index. Digit k is driven low when all of the following hold:
  - ENABLE=1
  - prescaler >= DEAD_CYCLES
  - BLANK[k]=0
  - k==index
  - (optional feature) the digit is not suppressed
- Otherwise all digits are high and oSeg_n=7'h7F.
- Each digit is lit for SCAN_DIV-DEAD_CYCLES cycles per slot, lagging the counters by 1 cycle.
- Segment table (nibble -> oSeg_n):
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, B:03
  - C:46, D:21, E:06, F:0E
- Simultaneous write and scan tick: the counter advances normally. The new register value is used from the following cycle.
- ENABLE 1->0 mid-slot: outputs blank on the next edge and counters return to 0. 0->1 starts at index 0, prescaler 0.

Optional Feature:
HEX_LEADING_ZERO_BLANK_EN.
- Defined: digit k (k>=1) is suppressed (held off) when all VALUE nibbles k..NUM_DIGITS-1 are 0. Digit 0 is never suppressed, so value 0 shows a single "0".
- Not defined: all non-BLANKed digits are displayed, including leading zeros.

Test Plan:
- Reset and enable (NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1):
  - Reset -> oSeg_n=7F, oDigit_n=F.
  - Write VALUE=0x0000_3A1F, CTRL=1 -> repeating pattern of 1 dead cycle then 3 cycles each:
    - oDigit_n=E, oSeg_n=0E
    - oDigit_n=D, oSeg_n=79
    - oDigit_n=B, oSeg_n=08
    - oDigit_n=7, oSeg_n=30
- Readback: read addr0 -> oReadData=0x0000_3A1F one cycle later. Write CTRL=0xFFFF_0201, read addr1 -> 0x0000_0201.
- Blanking and disable:
  - CTRL=0x0000_0201 -> digit 1 slot shows oDigit_n=F, oSeg_n=7F.
  - Write CTRL=0 mid-slot -> next edge all off. Re-enable -> scan restarts at digit 0.
- Mid-slot write: change VALUE to 0x0000_0008 during a digit-0 slot -> oSeg_n becomes 00 within 2 edges, with no change to slot timing.
- Reset mid-scan: assert iReset_n low between edges -> outputs go to F/7F immediately. Registers read 0 after release.
- HEX_LEADING_ZERO_BLANK_EN defined, VALUE=0x0000_0050 -> only digits 0 (40) and 1 (12) light; digits 2,3 stay off. VALUE=0 -> only digit 0 shows 40.
